// File: rtl/region_pkg.sv
// Shared types and limits for the region BRAM responder.
// Holds the sweep FSM encoding and the maximum read pipe depth.
package region_pkg;

  typedef enum logic [0:0] {
    STATE_IDLE  = 1'b0,
    STATE_CLEAR = 1'b1
  } t_region_state;

  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/region_bram_responder_if.sv
// Region port: one write channel and one fixed-latency read channel.
// master = compute-side requester, slave = memory responder.
interface region_bram_responder_if #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 10
);

  logic                  we;
  logic [LOG2_DEPTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic                  re;
  logic [LOG2_DEPTH-1:0] raddr;
  logic                  rvalid;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output we, waddr, wdata,
    output re, raddr,
    input  rvalid, rdata
  );

  modport slave (
    input  we, waddr, wdata,
    input  re, raddr,
    output rvalid, rdata
  );

endinterface

// File: rtl/region_read_pipe.sv
// READ_LATENCY-deep valid/data delay line for region reads.
// Synchronous active-low flush zeroes valid and data.
module region_read_pipe #(
  parameter int WIDTH        = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             flush_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0] v_q;
  logic [WIDTH-1:0]        d_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!flush_n) begin
      v_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      d_q[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[READ_LATENCY-1];
  assign out_data  = d_q[READ_LATENCY-1];

endmodule

// File: rtl/region_bram_responder.sv
// Region BRAM responder: fixed-latency reads, 1 write/cycle, clear sweep.
// REGION_BRAM_RESPONDER_BYPASS_EN selects write-first same-address reads.
module region_bram_responder
  import region_pkg::*;
#(
  parameter int WIDTH        = 512,
  parameter int LOG2_DEPTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_start,
  output logic clear_done,
  output logic busy,
  output logic err_dropped,
  region_bram_responder_if.slave bus
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] CLR_LAST =
    (LOG2_DEPTH+1)'(DEPTH - 1);
  localparam logic [LOG2_DEPTH:0] CLR_ONE =
    (LOG2_DEPTH+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  t_region_state       state_q;
  t_region_state       state_d;
  logic [LOG2_DEPTH:0] clr_q;
  logic                done_q;
  logic                last_clr;
  logic                rd_acc;
  logic                wr_acc;
  logic                clr_we;
  logic [WIDTH-1:0]    rd_word;

  assign last_clr = (clr_q == CLR_LAST);

  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= STATE_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_IDLE:  if (clear_start) state_d = STATE_CLEAR;
      STATE_CLEAR: if (last_clr)    state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    unique case (state_q)
      STATE_IDLE: begin
        rd_acc = bus.re;
        wr_acc = bus.we;
      end
      STATE_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
    endcase
  end

  assign clear_done = done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_q       <= '0;
      done_q      <= 1'b0;
      err_dropped <= 1'b0;
    end else begin
      done_q <= clr_we && last_clr;
      if (state_q == STATE_IDLE && clear_start) begin
        clr_q       <= '0;
        err_dropped <= 1'b0;
      end else if (clr_we) begin
        clr_q <= clr_q + CLR_ONE;
        if (bus.re || bus.we)
          err_dropped <= 1'b1;
      end
    end
  end

  // No memory access of any kind while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (clr_we)
        mem[clr_q[LOG2_DEPTH-1:0]] <= '0;
      else if (wr_acc)
        mem[bus.waddr] <= bus.wdata;
    end
  end

`ifdef REGION_BRAM_RESPONDER_BYPASS_EN
  assign rd_word = (wr_acc && bus.waddr == bus.raddr)
                 ? bus.wdata : mem[bus.raddr];
`else
  assign rd_word = mem[bus.raddr];
`endif

  region_read_pipe #(
    .WIDTH       (WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe (
    .clk      (clk),
    .flush_n  (reset),
    .in_valid (rd_acc),
    .in_data  (rd_word),
    .out_valid(bus.rvalid),
    .out_data (bus.rdata)
  );

endmodule

// File: tb/tb_region_bram_responder.sv
// Bench for region_bram_responder: scenario tasks plus random traffic
// checked against an array/queue-level behavioural model.
module tb_region_bram_responder;

  localparam int W     = 32;
  localparam int LD    = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 16;
  localparam int NC    = 4096;
`ifdef REGION_BRAM_RESPONDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_start = 1'b0;
  logic clear_done;
  logic busy;
  logic err_dropped;

  region_bram_responder_if #(.WIDTH(W), .LOG2_DEPTH(LD)) bus ();

  region_bram_responder #(
    .WIDTH(W), .LOG2_DEPTH(LD), .READ_LATENCY(RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_done (clear_done),
    .busy       (busy),
    .err_dropped(err_dropped),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic         obs_v    [NC];
  logic [W-1:0] obs_d    [NC];
  logic         obs_busy [NC];
  logic         obs_done [NC];
  logic         obs_err  [NC];
  bit           exp_v    [NC];
  logic [W-1:0] exp_d    [NC];
  bit           exp_busy [NC];
  bit           exp_done [NC];
  bit           exp_err  [NC];

  logic [W-1:0] m_mem [DEPTH];
  int           m_left = 0;
  bit           m_err  = 1'b0;

  task automatic drive(input bit re, input int ra, input bit we,
                       input int wa, input logic [W-1:0] wd,
                       input bit cs);
    bus.re      = re;
    bus.raddr   = LD'(ra);
    bus.we      = we;
    bus.waddr   = LD'(wa);
    bus.wdata   = wd;
    clear_start = cs;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  // Records what the DUT presents at edge cyc, advances the model by
  // one edge with the current inputs, then crosses the edge.
  task automatic tick();
    obs_v[cyc]    = bus.rvalid;
    obs_d[cyc]    = bus.rdata;
    obs_busy[cyc] = busy;
    obs_done[cyc] = clear_done;
    obs_err[cyc]  = err_dropped;
    if (!reset) begin
      for (int j = 1; j <= RL; j++) exp_v[cyc+j] = 1'b0;
      m_left = 0;
      m_err  = 1'b0;
      exp_done[cyc+1] = 1'b0;
    end else if (m_left > 0) begin
      if (bus.re || bus.we) m_err = 1'b1;
      m_mem[DEPTH-m_left] = '0;
      m_left--;
      exp_done[cyc+1] = (m_left == 0);
    end else begin
      if (bus.re) begin
        exp_v[cyc+RL] = 1'b1;
        exp_d[cyc+RL] = (BYP && bus.we && bus.waddr == bus.raddr)
                      ? bus.wdata : m_mem[bus.raddr];
      end
      if (bus.we) m_mem[bus.waddr] = bus.wdata;
      if (clear_start) begin
        m_left = DEPTH;
        m_err  = 1'b0;
      end
      exp_done[cyc+1] = 1'b0;
    end
    exp_busy[cyc+1] = (m_left > 0);
    exp_err[cyc+1]  = m_err;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, 1'b1, a, $urandom, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    int c0 = cyc;
    reset = 1'b0;
    drive(1'b1, 1, 1'b1, 1, 32'h5a5a, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    idle();
    repeat (5) tick();
    for (int k = c0 + 1; k <= c0 + 3; k++) begin
      total++;
      if (obs_v[k] !== 1'b0 || obs_busy[k] !== 1'b0 ||
          obs_done[k] !== 1'b0 || obs_err[k] !== 1'b0 ||
          obs_d[k] !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d v=%b busy=%b done=%b err=%b rdata=%h required all 0",
                 k, obs_v[k], obs_busy[k], obs_done[k], obs_err[k], obs_d[k]);
      end
    end
    for (int k = c0 + 4; k < cyc; k++) begin
      total++;
      if (obs_v[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_rvalid cyc=%0d rvalid=%b required 0",
                 k, obs_v[k]);
      end
    end
  endtask

  task automatic test_stream();
    int r0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 0, 1'b1, i, W'(32'hA0 + i), 1'b0);
      tick();
    end
    r0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 1'b0, 0, '0, 1'b0);
      tick();
    end
    idle();
    repeat (RL + 3) tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_v[r0+RL+i] !== 1'b1 ||
          obs_d[r0+RL+i] !== W'(32'hA0 + i)) begin
        bad++;
        $display("FAIL stream_read i=%0d got v=%b d=%h required v=1 d=%h",
                 i, obs_v[r0+RL+i], obs_d[r0+RL+i], W'(32'hA0 + i));
      end
    end
    total++;
    if (obs_v[r0+RL-1] !== 1'b0 || obs_v[r0+RL+8] !== 1'b0) begin
      bad++;
      $display("FAIL stream_edges got before=%b after=%b required 0 0",
               obs_v[r0+RL-1], obs_v[r0+RL+8]);
    end
  endtask

  task automatic test_collision();
    int r1;
    int r2;
    logic [W-1:0] want1;
    drive(1'b0, 0, 1'b1, 5, 32'h11, 1'b0);
    tick();
    r1 = cyc;
    drive(1'b1, 5, 1'b1, 5, 32'h22, 1'b0);
    tick();
    r2 = cyc;
    drive(1'b1, 5, 1'b0, 0, '0, 1'b0);
    tick();
    idle();
    repeat (RL + 2) tick();
    want1 = BYP ? 32'h22 : 32'h11;
    total++;
    if (obs_v[r1+RL] !== 1'b1 || obs_d[r1+RL] !== want1) begin
      bad++;
      $display("FAIL collision_same_cycle got v=%b d=%h required v=1 d=%h",
               obs_v[r1+RL], obs_d[r1+RL], want1);
    end
    total++;
    if (obs_v[r2+RL] !== 1'b1 || obs_d[r2+RL] !== 32'h22) begin
      bad++;
      $display("FAIL collision_follow got v=%b d=%h required v=1 d=22",
               obs_v[r2+RL], obs_d[r2+RL]);
    end
  endtask

  task automatic test_sweep();
    int s;
    int r0;
    int nb = 0;
    int nd = 0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, 1'b1, a, 32'hFF, 1'b0);
      tick();
    end
    s = cyc;
    drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
    tick();
    idle();
    repeat (DEPTH + 4) tick();
    for (int k = s + 1; k <= s + DEPTH + 4; k++) begin
      nb += int'(obs_busy[k] === 1'b1);
      nd += int'(obs_done[k] === 1'b1);
    end
    total++;
    if (nb != DEPTH || obs_busy[s+1] !== 1'b1 ||
        obs_busy[s+DEPTH] !== 1'b1 ||
        obs_busy[s+DEPTH+1] !== 1'b0) begin
      bad++;
      $display("FAIL sweep_busy got count=%0d first=%b last=%b after=%b required %0d 1 1 0",
               nb, obs_busy[s+1], obs_busy[s+DEPTH],
               obs_busy[s+DEPTH+1], DEPTH);
    end
    total++;
    if (nd != 1 || obs_done[s+DEPTH+1] !== 1'b1) begin
      bad++;
      $display("FAIL sweep_done got count=%0d at_end=%b required 1 1",
               nd, obs_done[s+DEPTH+1]);
    end
    r0 = cyc;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, a, 1'b0, 0, '0, 1'b0);
      tick();
    end
    idle();
    repeat (RL + 1) tick();
    for (int a = 0; a < DEPTH; a++) begin
      total++;
      if (obs_v[r0+RL+a] !== 1'b1 || obs_d[r0+RL+a] !== '0) begin
        bad++;
        $display("FAIL sweep_zero addr=%0d got v=%b d=%h required v=1 d=0",
                 a, obs_v[r0+RL+a], obs_d[r0+RL+a]);
      end
    end
  endtask

  task automatic test_drop();
    int e;
    int m;
    int r;
    int c;
    drive(1'b0, 0, 1'b1, 3, 32'h33, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1, 2, 32'h44, 1'b0);
    tick();
    e = cyc;
    drive(1'b1, 3, 1'b0, 0, '0, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    m = cyc;
    drive(1'b1, 7, 1'b1, 2, 32'h55, 1'b0);
    tick();
    idle();
    repeat (DEPTH) tick();
    total++;
    if (obs_v[e+RL] !== 1'b1 || obs_d[e+RL] !== 32'h33) begin
      bad++;
      $display("FAIL drop_preclear_read got v=%b d=%h required v=1 d=33",
               obs_v[e+RL], obs_d[e+RL]);
    end
    total++;
    if (obs_v[m+RL] !== 1'b0 || obs_err[m] !== 1'b0 ||
        obs_err[cyc-1] !== 1'b1) begin
      bad++;
      $display("FAIL drop_flag got rvalid=%b err_before=%b err_after=%b required 0 0 1",
               obs_v[m+RL], obs_err[m], obs_err[cyc-1]);
    end
    r = cyc;
    drive(1'b1, 2, 1'b0, 0, '0, 1'b0);
    tick();
    idle();
    repeat (RL + 1) tick();
    total++;
    if (obs_v[r+RL] !== 1'b1 || obs_d[r+RL] !== '0) begin
      bad++;
      $display("FAIL drop_write_ignored got v=%b d=%h required v=1 d=0",
               obs_v[r+RL], obs_d[r+RL]);
    end
    c = cyc;
    drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
    tick();
    idle();
    repeat (DEPTH + 2) tick();
    total++;
    if (obs_err[c] !== 1'b1 || obs_err[c+1] !== 1'b0) begin
      bad++;
      $display("FAIL drop_err_clear got before=%b after=%b required 1 0",
               obs_err[c], obs_err[c+1]);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    int r0;
    int nd = 0;
    int nb = 0;
    int addrs [8] = '{0, 1, 2, 3, 4, 5, 6, 10};
    fill_rand();
    drive(1'b0, 0, 1'b1, 10, 32'hABCD, 1'b0);
    tick();
    s = cyc;
    drive(1'b0, 0, 1'b0, 0, '0, 1'b1);
    tick();
    idle();
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (DEPTH + 2) tick();
    for (int k = s + 1; k < cyc; k++)
      nd += int'(obs_done[k] !== 1'b0);
    for (int k = s + 8; k < cyc; k++)
      nb += int'(obs_busy[k] !== 1'b0);
    total++;
    if (nd != 0 || nb != 0) begin
      bad++;
      $display("FAIL midreset_flags got done_cycles=%0d busy_cycles=%0d required 0 0",
               nd, nb);
    end
    r0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, addrs[i], 1'b0, 0, '0, 1'b0);
      tick();
    end
    idle();
    repeat (RL + 1) tick();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] want;
      want = (i < 6) ? '0 : exp_d[r0+RL+i];
      if (i == 7) want = 32'hABCD;
      total++;
      if (obs_v[r0+RL+i] !== 1'b1 || obs_d[r0+RL+i] !== want) begin
        bad++;
        $display("FAIL midreset_line addr=%0d got v=%b d=%h required v=1 d=%h",
                 addrs[i], obs_v[r0+RL+i], obs_d[r0+RL+i], want);
      end
    end
  endtask

  task automatic test_random();
    int c0 = cyc;
    int wa;
    int ra;
    for (int n = 0; n < 120; n++) begin
      wa = int'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 2) == 0) ? wa
         : int'($urandom_range(0, DEPTH - 1));
      drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
            wa, $urandom, ($urandom_range(0, 39) == 0));
      tick();
    end
    idle();
    repeat (DEPTH + RL + 2) tick();
    for (int k = c0 + 1; k < cyc; k++) begin
      total++;
      if (obs_v[k] !== exp_v[k] ||
          (exp_v[k] && obs_d[k] !== exp_d[k]) ||
          obs_busy[k] !== exp_busy[k] ||
          obs_done[k] !== exp_done[k] ||
          obs_err[k] !== exp_err[k]) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b d=%h busy=%b done=%b err=%b required v=%b d=%h busy=%b done=%b err=%b",
                 k, obs_v[k], obs_d[k], obs_busy[k], obs_done[k],
                 obs_err[k], exp_v[k], exp_d[k], exp_busy[k],
                 exp_done[k], exp_err[k]);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    fill_rand();
    test_stream();
    test_collision();
    test_sweep();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
